mic_tx_sched: RTL and testbench
===============================

Name: mic_tx_sched

Overview:
Scheduler that shares the single UART word transmitter among NUM_CH microphone sample FIFOs. Emits framed packets: one sync/header word, then SAMPLES_PER_FRAME rounds visiting every channel in fixed order 0..NUM_CH-1. Capture start/stop come from key-derived pulses. Sits between the per-channel async FIFOs (read side, sys_clk domain) and uart_top.

Parameters:
NUM_CH, 2, number of mic channel FIFOs (1..8)
DW, 16, sample/word width
SAMPLES_PER_FRAME, 64, rounds per frame (>=1)
SYNC_WORD, 16'hA5A5, first word of every frame
TIMEOUT, 1024, sys_clk cycles to wait on an empty FIFO before substituting FILL_WORD
FILL_WORD, 16'h8000, substitute sample on timeout

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
cap_start  in  1  one-cycle pulse: begin framing
cap_stop  in  1  one-cycle pulse: stop after current frame
ch_empty  in  NUM_CH  FIFO empty flags, bit i = channel i
ch_data  in  NUM_CH*DW  FIFO Q buses, channel i at [i*DW +: DW]; valid 1 cycle after ch_rd_en
ch_rd_en  out  NUM_CH  one-hot read strobe, at most one bit high per cycle
tx_data  out  DW  word to UART
tx_valid  out  1  word on tx_data is valid
tx_ready  in  1  one-cycle pulse: UART accepted tx_data
cap_active  out  1  high from start acceptance until last word of final frame accepted
frame_cnt  out  16  completed frames, wraps 16'hFFFF->0
underrun  out  1  sticky: a timeout substitution occurred; cleared on cap_start

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, stop_pending 0.
- States: IDLE, HDR, RD, LAT, SEND, NEXT.
- IDLE: cap_start -> HDR; cap_active=1; underrun cleared. cap_stop ignored in IDLE.
- HDR: tx_data=SYNC_WORD, tx_valid=1 until tx_ready; then ch=0, round=0 -> RD.
- RD: if !ch_empty[ch]: ch_rd_en[ch]=1 for exactly this cycle -> LAT. Else count wait cycles; at TIMEOUT-1 without data: latch FILL_WORD, set underrun -> SEND (no read strobe). Wait counter resets on entry to RD.
- LAT: capture ch_data[ch] into tx_data register -> SEND.
- SEND: tx_valid=1, tx_data stable until tx_ready; tx_valid drops the cycle after tx_ready. -> NEXT.
- NEXT (1 cycle): if ch<NUM_CH-1: ch++ -> RD. Else ch=0; if round<SAMPLES_PER_FRAME-1: round++ -> RD; else frame_cnt++ and: stop_pending -> IDLE (cap_active=0, stop_pending=0), otherwise -> HDR.
- cap_stop in any non-IDLE state sets stop_pending; current frame always completes (no truncated frames on link).
- cap_start while active: ignored. cap_start and cap_stop same cycle in IDLE: start wins, stop_pending set (exactly one frame sent).
- tx_ready while tx_valid=0: ignored.
- Minimum per-sample overhead: RD+LAT+NEXT = 3 cycles plus UART time; rd_en never issued while a word awaits tx_ready (no FIFO over-read).
- Async reset mid-frame: immediate return to IDLE, tx_valid/ch_rd_en low; partial frame abandoned, receiver resyncs on SYNC_WORD.

Optional Feature:
MIC_TX_SCHED_CKSUM_EN: defined -> 16-bit running sum (mod 2^16) of all sample words (incl. FILL_WORD, excl. SYNC_WORD) of the frame is sent as an extra word after the last sample, via state CKS before NEXT's frame-end decision; sum cleared in HDR. Undefined -> no CKS state, frame = 1 + NUM_CH*SAMPLES_PER_FRAME words.

Decomposition:
- Package mic_pkg: state enum encoding, SYNC_WORD/FILL_WORD defaults, DW.
- One sub-module natural: mic_tx_timeout (loadable down-counter, start/expire pulse) used by RD.

Test Plan:
- NUM_CH=2, SPF=2, FIFOs preloaded ch0={1,2}, ch1={3,4}, tx_ready 5 cycles after each tx_valid, cap_start+cap_stop together -> words A5A5,1,3,2,4; frame_cnt=1; cap_active falls after last accept.
- ch1 kept empty, TIMEOUT=16 -> ch1 slots carry 8000 after 16 cycles wait, underrun=1, no ch_rd_en[1] pulse.
- cap_stop mid-frame (after 3rd sample) -> frame finishes all 2*SPF samples, then IDLE, no further HDR.
- Reset asserted during SEND -> tx_valid, ch_rd_en, cap_active low same time; after release cap_start yields fresh A5A5.
- Spurious tx_ready in IDLE and RD -> no state/output change; ch_rd_en checked one-hot/zero every cycle.
- With MIC_TX_SCHED_CKSUM_EN, samples 1,3,2,4 -> extra word 000A before next A5A5.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared types and defaults for the microphone-to-UART transmit scheduler.
package mic_pkg;

  localparam int MIC_DW = 16;
  localparam logic [MIC_DW-1:0] SYNC_WORD_DEF = 16'hA5A5;
  localparam logic [MIC_DW-1:0] FILL_WORD_DEF = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_RD   = 3'd2,
    ST_LAT  = 3'd3,
    ST_SEND = 3'd4,
    ST_NEXT = 3'd5
`ifdef MIC_TX_SCHED_CKSUM_EN
    ,
    ST_CKS  = 3'd6
`endif
  } state_e;

  // Counter width that stays legal (>=1 bit) for a range of a single value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mic_tx_timeout.sv
// Loadable down-counter: start reloads it, expire pulses on the TIMEOUT-th enabled cycle.
module mic_tx_timeout
  import mic_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic en,
  output logic expire
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/mic_tx_sched.sv
// Round-robin framer sharing one UART word transmitter among NUM_CH mic FIFOs.
// Optional per-frame checksum word: define MIC_TX_SCHED_CKSUM_EN.
module mic_tx_sched
  import mic_pkg::*;
#(
  parameter int              NUM_CH            = 2,
  parameter int              DW                = MIC_DW,
  parameter int              SAMPLES_PER_FRAME = 64,
  parameter logic [DW-1:0]   SYNC_WORD         = SYNC_WORD_DEF,
  parameter int              TIMEOUT           = 1024,
  parameter logic [DW-1:0]   FILL_WORD         = FILL_WORD_DEF
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 cap_start,
  input  logic                 cap_stop,
  input  logic [NUM_CH-1:0]    ch_empty,
  input  logic [NUM_CH*DW-1:0] ch_data,
  output logic [NUM_CH-1:0]    ch_rd_en,
  output logic [DW-1:0]        tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 cap_active,
  output logic [15:0]          frame_cnt,
  output logic                 underrun
);

  localparam int CHW = cnt_width(NUM_CH);
  localparam int RW  = cnt_width(SAMPLES_PER_FRAME);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(NUM_CH - 1);
  localparam logic [RW-1:0]  LAST_RND = RW'(SAMPLES_PER_FRAME - 1);

  state_e         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [RW-1:0]  round_q, round_d;
  logic [DW-1:0]  word_q, word_d;
  logic [15:0]    frame_q, frame_d;
  logic           underrun_q, underrun_d;
  logic           stop_q, stop_d;
  logic           tmo_start, tmo_en, tmo_expire;
  logic           frame_done;
  logic [DW-1:0]  ch_word;
`ifdef MIC_TX_SCHED_CKSUM_EN
  logic [DW-1:0]  sum_q, sum_d;
`endif

  assign ch_word = ch_data[int'(ch_q)*DW +: DW];
  assign tmo_en  = (state_q == ST_RD) && ch_empty[ch_q];

  mic_tx_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .start  (tmo_start),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      round_q    <= '0;
      word_q     <= '0;
      frame_q    <= '0;
      underrun_q <= 1'b0;
      stop_q     <= 1'b0;
`ifdef MIC_TX_SCHED_CKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      round_q    <= round_d;
      word_q     <= word_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
      stop_q     <= stop_d;
`ifdef MIC_TX_SCHED_CKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    round_d    = round_q;
    word_d     = word_q;
    frame_d    = frame_q;
    underrun_d = underrun_q;
    stop_d     = stop_q;
    tmo_start  = 1'b0;
    frame_done = 1'b0;
`ifdef MIC_TX_SCHED_CKSUM_EN
    sum_d      = sum_q;
`endif

    // A stop request never truncates a frame; it is only honoured at frame end.
    if ((state_q != ST_IDLE) && cap_stop) stop_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (cap_start) begin
          state_d    = ST_HDR;
          underrun_d = 1'b0;
          stop_d     = cap_stop;
        end
      end
      ST_HDR: begin
`ifdef MIC_TX_SCHED_CKSUM_EN
        sum_d = '0;
`endif
        if (tx_ready) begin
          ch_d      = '0;
          round_d   = '0;
          tmo_start = 1'b1;
          state_d   = ST_RD;
        end
      end
      ST_RD: begin
        if (!ch_empty[ch_q]) begin
          state_d = ST_LAT;
        end else if (tmo_expire) begin
          word_d     = FILL_WORD;
          underrun_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_LAT: begin
        word_d  = ch_word;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
`ifdef MIC_TX_SCHED_CKSUM_EN
          sum_d = sum_q + word_q;
`endif
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        tmo_start = 1'b1;
        state_d   = ST_RD;
        if (ch_q != LAST_CH) begin
          ch_d = ch_q + 1'b1;
        end else begin
          ch_d = '0;
          if (round_q != LAST_RND) begin
            round_d = round_q + 1'b1;
          end else begin
            tmo_start = 1'b0;
`ifdef MIC_TX_SCHED_CKSUM_EN
            state_d = ST_CKS;
`else
            frame_done = 1'b1;
`endif
          end
        end
      end
`ifdef MIC_TX_SCHED_CKSUM_EN
      ST_CKS: begin
        if (tx_ready) frame_done = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (frame_done) begin
      frame_d = frame_q + 16'd1;
      if (stop_q || cap_stop) begin
        state_d = ST_IDLE;
        stop_d  = 1'b0;
      end else begin
        state_d = ST_HDR;
      end
    end
  end

  always_comb begin
    ch_rd_en = '0;
    if ((state_q == ST_RD) && !ch_empty[ch_q]) ch_rd_en[ch_q] = 1'b1;
  end

  always_comb begin
    tx_data  = word_q;
    tx_valid = (state_q == ST_HDR) || (state_q == ST_SEND);
    if (state_q == ST_HDR) tx_data = SYNC_WORD;
`ifdef MIC_TX_SCHED_CKSUM_EN
    if (state_q == ST_CKS) begin
      tx_data  = sum_q;
      tx_valid = 1'b1;
    end
`endif
  end

  assign cap_active = (state_q != ST_IDLE);
  assign frame_cnt  = frame_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_mic_tx_sched.sv
// Randomized self-checking bench for mic_tx_sched against a frame-level word-stream model.
module tb_mic_tx_sched;

  localparam int NUM_CH  = 2;
  localparam int DW      = 16;
  localparam int SPF     = 2;
  localparam int TIMEOUT = 16;
  localparam logic [DW-1:0] SYNC = 16'hA5A5;
  localparam logic [DW-1:0] FILL = 16'h8000;
`ifdef MIC_TX_SCHED_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int NS  = NUM_CH * SPF;
  localparam int WPF = 1 + NS + CK;

  logic                 clk;
  logic                 rst_n;
  logic                 cap_start;
  logic                 cap_stop;
  logic [NUM_CH-1:0]    ch_empty = '1;
  logic [NUM_CH*DW-1:0] ch_data  = '0;
  logic [NUM_CH-1:0]    ch_rd_en;
  logic [DW-1:0]        tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 cap_active;
  logic [15:0]          frame_cnt;
  logic                 underrun;

  mic_tx_sched #(
    .NUM_CH           (NUM_CH),
    .DW               (DW),
    .SAMPLES_PER_FRAME(SPF),
    .SYNC_WORD        (SYNC),
    .TIMEOUT          (TIMEOUT),
    .FILL_WORD        (FILL)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .cap_start (cap_start),
    .cap_stop  (cap_stop),
    .ch_empty  (ch_empty),
    .ch_data   (ch_data),
    .ch_rd_en  (ch_rd_en),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .cap_active(cap_active),
    .frame_cnt (frame_cnt),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bench-side FIFOs, transmit capture and per-cycle bookkeeping.
  logic [DW-1:0] fifo_q [NUM_CH][$];
  logic [15:0]   cap_w[$];
  int            cap_gap[$];
  int            rd_cnt [NUM_CH];
  int            over_rd    = 0;
  int            low_run    = 0;
  int            wait_cnt   = 0;
  int            delay_mode = 0;
  int            exp_frames = 0;
  bit            ready_en   = 1'b0;
  bit            spur_en    = 1'b1;
  bit            prev_pending = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  function automatic int next_delay();
    return (delay_mode >= 0) ? delay_mode : int'($urandom_range(0, 6));
  endfunction

  // FIFO read port: registered Q one cycle after the read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_rd_en[i]) begin
        if (fifo_q[i].size() > 0) ch_data[i*DW +: DW] <= fifo_q[i].pop_front();
        else over_rd++;
      end
    end
    for (int i = 0; i < NUM_CH; i++) ch_empty[i] <= (fifo_q[i].size() == 0);
  end

  // UART side: ready pulses after a delay, spurious ready while idle, per-cycle protocol checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_ready     = 1'b0;
      prev_pending = 1'b0;
    end else begin
      check("rd_onehot", 32'($onehot0(ch_rd_en)), 32'd1);
      check("rd_while_valid", 32'((|ch_rd_en) && tx_valid), 32'd0);
      for (int i = 0; i < NUM_CH; i++) if (ch_rd_en[i]) rd_cnt[i]++;
      if (prev_pending && tx_valid) check("tx_hold", 32'(tx_data), 32'(prev_data));
      if (tx_valid) begin
        if (ready_en && (wait_cnt == 0)) begin
          tx_ready = 1'b1;
          cap_w.push_back(tx_data);
          cap_gap.push_back(low_run);
          low_run      = 0;
          wait_cnt     = next_delay();
          prev_pending = 1'b0;
        end else begin
          tx_ready = 1'b0;
          if (ready_en && (wait_cnt > 0)) wait_cnt--;
          prev_pending = 1'b1;
          prev_data    = tx_data;
        end
      end else begin
        tx_ready     = spur_en && ($urandom_range(0, 2) == 0);
        low_run++;
        prev_pending = 1'b0;
      end
    end
  end

  task automatic wait_words(input int n, input string tag);
    int b = 0;
    while ((cap_w.size() < n) && (b < 5000)) begin
      @(negedge clk);
      b++;
    end
    check(tag, 32'(cap_w.size() >= n), 32'd1);
  endtask

  // One capture session: preload FIFOs, start, stop inside the last frame, compare the word stream.
  task automatic run_capture(input int n_frames, input logic [NUM_CH-1:0] starve, input int dly,
                             input bit stop_with_start, input bit directed);
    logic [DW-1:0] gen [NUM_CH][$];
    logic [15:0]   exp_w[$];
    int            exp_gap[$];
    logic [15:0]   sum;
    logic [DW-1:0] v;
    logic [DW-1:0] w;
    int            b;
    cap_w.delete();
    cap_gap.delete();
    for (int c = 0; c < NUM_CH; c++) rd_cnt[c] = 0;
    over_rd    = 0;
    delay_mode = dly;
    wait_cnt   = next_delay();
    ready_en   = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < n_frames * SPF; j++) begin
        v = directed ? DW'(c * SPF + j + 1) : DW'($urandom);
        gen[c].push_back(v);
        if (!starve[c]) fifo_q[c].push_back(v);
      end
    end
    for (int f = 0; f < n_frames; f++) begin
      exp_w.push_back(SYNC);
      exp_gap.push_back(-1);
      sum = '0;
      for (int r = 0; r < SPF; r++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          w = starve[c] ? FILL : gen[c][f*SPF + r];
          sum += w;
          exp_w.push_back(w);
          exp_gap.push_back(((r == 0 && c == 0) ? 0 : 1) + (starve[c] ? TIMEOUT : 2));
        end
      end
      if (CK == 1) begin
        exp_w.push_back(sum);
        exp_gap.push_back(-1);
      end
    end

    repeat (2) @(negedge clk);
    cap_start = 1'b1;
    cap_stop  = stop_with_start;
    @(negedge clk);
    cap_start = 1'b0;
    cap_stop  = 1'b0;
    if (!stop_with_start) begin
      wait_words((n_frames - 1) * WPF + 1 + int'($urandom_range(0, NS - 1)), "stop_point");
      cap_start = 1'b1;
      cap_stop  = 1'b1;
      @(negedge clk);
      cap_start = 1'b0;
      cap_stop  = 1'b0;
    end

    b = 0;
    while (cap_active && (b < 20000)) begin
      @(negedge clk);
      b++;
    end
    check("cap_active_fall", 32'(cap_active), 32'd0);
    check("words_at_fall", 32'(cap_w.size()), 32'(exp_w.size()));
    repeat (30) @(negedge clk);
    check("word_count", 32'(cap_w.size()), 32'(exp_w.size()));
    check("tx_valid_idle", 32'(tx_valid), 32'd0);
    for (int i = 0; i < exp_w.size(); i++) begin
      if (i < cap_w.size()) begin
        check($sformatf("word%0d", i), 32'(cap_w[i]), 32'(exp_w[i]));
        if (exp_gap[i] >= 0) check($sformatf("gap%0d", i), 32'(cap_gap[i]), 32'(exp_gap[i]));
      end
    end
    exp_frames += n_frames;
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("underrun", 32'(underrun), 32'(|starve));
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("rd_cnt%0d", c), 32'(rd_cnt[c]), 32'(starve[c] ? 0 : n_frames * SPF));
    check("over_read", 32'(over_rd), 32'd0);
  endtask

  task automatic reset_in_send();
    int b = 0;
    cap_w.delete();
    cap_gap.delete();
    delay_mode = 2;
    wait_cnt   = next_delay();
    ready_en   = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      for (int j = 0; j < 4; j++) fifo_q[c].push_back(DW'($urandom));
    repeat (2) @(negedge clk);
    cap_start = 1'b1;
    @(negedge clk);
    cap_start = 1'b0;
    wait_words(1, "rst_sync_seen");
    ready_en = 1'b0;
    while (!tx_valid && (b < 200)) begin
      @(negedge clk);
      b++;
    end
    check("rst_send_reached", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rd_en", 32'(ch_rd_en), 32'd0);
    check("rst_cap_active", 32'(cap_active), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (3) @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) fifo_q[c].delete();
    exp_frames = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_capture(1, '0, 3, 1'b1, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cap_start = 1'b0;
    cap_stop  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_rd_en", 32'(ch_rd_en), 32'd0);
    check("reset_cap_active", 32'(cap_active), 32'd0);
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;

    // Stop alone and spurious ready in IDLE change nothing.
    repeat (2) @(negedge clk);
    cap_stop = 1'b1;
    @(negedge clk);
    cap_stop = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_cap_active", 32'(cap_active), 32'd0);
    check("idle_tx_valid", 32'(tx_valid), 32'd0);
    check("idle_frame_cnt", 32'(frame_cnt), 32'd0);

    run_capture(1, 2'b00, 5, 1'b1, 1'b1);
    run_capture(1, 2'b10, -1, 1'b1, 1'b0);
    run_capture(3, 2'b00, -1, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++)
      run_capture(int'($urandom_range(1, 3)), NUM_CH'($urandom_range(0, 3)), -1, 1'b0, 1'b0);
    reset_in_send();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
